// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//
// Drives every input vector 0 .. 2**N_IN-1 into an external combinational DUT.
// Each vector is held for DWELL cycles. The DUT output y_in is sampled on the
// last cycle of each vector and compared against a golden truth table. The
// golden table is captured once, when the sweep starts.
//
// Parameters
//   N_IN   number of DUT inputs driven (1..6)
//   DWELL  clock cycles each vector is held (1..1023)
//
// Ports
//   clk           sole clock, rising edge
//   reset         synchronous active-high reset
//   start         begin a sweep (honoured in IDLE and DONE, ignored in RUN)
//   expected      golden truth table, bit i = expected y for vector i
//   y_in          DUT output under test
//   vec           vector currently driven to the DUT
//   busy          sweep in progress
//   done          holding the result of a completed sweep
//   pass          done and no mismatches
//   captured      measured truth table, bit i = y_in sampled for vector i
//   mismatch_cnt  number of vectors where y_in differed from expected
module truth_table_sweeper #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned DWELL = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2**N_IN-1:0]     expected,
    input  logic                   y_in,
    output logic [N_IN-1:0]        vec,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [2**N_IN-1:0]     captured,
    output logic [N_IN:0]          mismatch_cnt
);

    localparam int unsigned NumVec = 2 ** N_IN;
    localparam int unsigned DwW    = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DwW-1:0]  DwellLast = DwW'(DWELL - 1);
    localparam logic [N_IN-1:0] VecLast   = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [N_IN-1:0]     vec_q, vec_d;
    logic [DwW-1:0]      dwell_q, dwell_d;
    logic [NumVec-1:0]   exp_q, exp_d;
    logic [NumVec-1:0]   cap_q, cap_d;
    logic [N_IN:0]       mis_q, mis_d;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        dwell_d = dwell_q;
        exp_d   = exp_q;
        cap_d   = cap_q;
        mis_d   = mis_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    vec_d   = '0;
                    dwell_d = '0;
                    cap_d   = '0;
                    mis_d   = '0;
                    exp_d   = expected;
                end
            end

            StRun: begin
                if (dwell_q == DwellLast) begin
                    // Last cycle of this vector: record the sample.
                    cap_d[vec_q] = y_in;
                    // One increment per vector at most, so the
                    // N_IN+1 bit counter tops out at 2**N_IN and cannot wrap.
                    if (y_in != exp_q[vec_q]) begin
                        mis_d = mis_q + (N_IN + 1)'(1);
                    end
                    if (vec_q == VecLast) begin
                        state_d = StDone;
                    end else begin
                        vec_d   = vec_q + N_IN'(1);
                        dwell_d = '0;
                    end
                end else begin
                    dwell_d = dwell_q + DwW'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset takes priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            vec_q   <= '0;
            dwell_q <= '0;
            exp_q   <= '0;
            cap_q   <= '0;
            mis_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            dwell_q <= dwell_d;
            exp_q   <= exp_d;
            cap_q   <= cap_d;
            mis_q   <= mis_d;
        end
    end

    // Outputs come only from registered state.
    always_comb begin
        vec          = vec_q;
        captured     = cap_q;
        mismatch_cnt = mis_q;
        busy         = (state_q == StRun);
        done         = (state_q == StDone);
        pass         = (state_q == StDone) && (mis_q == '0);
    end

endmodule
